// File: rtl/control_sequencer_if.sv
// Bundle of the handshake, decoder and strobe signals around control_sequencer.
// master: the sequencer side (drives strobes). slave: the datapath/environment side.
// Optional interrupt signals exist only when CTRL_IRQ_EN is defined.
interface control_sequencer_if #(
  parameter int unsigned NUM_WB_PORTS = 2
);
  // Inputs to the sequencer
  logic                    run;
  logic                    fetch_done;
  logic                    mem_done;
  logic                    branch_en;
  logic                    new_status_en;
  logic [NUM_WB_PORTS-1:0] reg_wb_mode;
  logic [2:0]              branch_cond;
  logic [2:0]              macro_op;
  logic [15:0]             status_reg;
  // Outputs from the sequencer
  logic                    fetch_en;
  logic                    pc_fetch_wr;
  logic                    pc_branch_wr;
  logic                    decode_en;
  logic                    alu_in_en;
  logic                    alu_out_en;
  logic                    status_wr;
  logic [NUM_WB_PORTS-1:0] reg_wr_en;
  logic                    mem_req;
  logic                    mem_wr;
  logic                    fault;
  logic [3:0]              state_o;
`ifdef CTRL_IRQ_EN
  logic                    irq_req;
  logic                    irq_ack;
  logic                    pc_vector_wr;
`endif

  modport master (
    input  run, fetch_done, mem_done, branch_en, new_status_en,
    input  reg_wb_mode, branch_cond, macro_op, status_reg,
`ifdef CTRL_IRQ_EN
    input  irq_req,
    output irq_ack, pc_vector_wr,
`endif
    output fetch_en, pc_fetch_wr, pc_branch_wr, decode_en, alu_in_en,
    output alu_out_en, status_wr, reg_wr_en, mem_req, mem_wr, fault, state_o
  );

  modport slave (
    output run, fetch_done, mem_done, branch_en, new_status_en,
    output reg_wb_mode, branch_cond, macro_op, status_reg,
`ifdef CTRL_IRQ_EN
    output irq_req,
    input  irq_ack, pc_vector_wr,
`endif
    input  fetch_en, pc_fetch_wr, pc_branch_wr, decode_en, alu_in_en,
    input  alu_out_en, status_wr, reg_wr_en, mem_req, mem_wr, fault, state_o
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the XMakina core.
// Sequences fetch, decode, operand/ALU, data memory and write-back strobes,
// with a fetch/memory wait counter that raises a sticky fault on timeout.
// Optional feature macro: CTRL_IRQ_EN adds an IRQ_ENTRY state between instructions.
//
// Handshake: fetch_en pulses for one cycle; the sequencer then waits in
// WAIT_FETCH until fetch_done. mem_req is a level held through MEM_WAIT and
// the access completes in the cycle mem_done is seen high. A done seen in the
// same cycle the wait counter expires wins over the timeout.
//
// All outputs are registered: the next-state logic also computes the strobe
// values that belong to the next state, so every strobe is high exactly while
// state_o shows its owning state.
module control_sequencer #(
  parameter int unsigned TIMEOUT_W     = 4,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned NUM_WB_PORTS  = 2
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    FETCH         = 4'd1,
    WAIT_FETCH    = 4'd2,
    DECODE        = 4'd3,
    OPERAND_FETCH = 4'd4,
    EXECUTE       = 4'd5,
    MEM_WAIT      = 4'd6,
    WRITE_BACK    = 4'd7,
    NOP_EXEC      = 4'd8,
    FAULT         = 4'd9
`ifdef CTRL_IRQ_EN
    , IRQ_ENTRY   = 4'd11
`endif
  } state_t;

  localparam logic [2:0] OP_LD  = 3'd3;
  localparam logic [2:0] OP_ST  = 3'd4;
  localparam logic [2:0] OP_SVC = 3'd5;
  localparam logic [2:0] OP_CEX = 3'd6;

  // Timeouts beyond what the counter can hold are clamped to its maximum.
  localparam int unsigned MAX_CNT   = (32'd1 << TIMEOUT_W) - 32'd1;
  localparam int unsigned FETCH_LIM = (FETCH_TIMEOUT > MAX_CNT) ? MAX_CNT : FETCH_TIMEOUT;
  localparam int unsigned MEM_LIM   = (MEM_TIMEOUT > MAX_CNT) ? MAX_CNT : MEM_TIMEOUT;

  state_t                  state, state_d;
  logic [TIMEOUT_W-1:0]    cnt, cnt_d;
  logic [TIMEOUT_W:0]      cnt_inc;
  logic [TIMEOUT_W-1:0]    cnt_sat;
  logic                    cond_true;
  state_t                  after_instr;

  logic                    fetch_en, fetch_en_d;
  logic                    pc_fetch_wr, pc_fetch_wr_d;
  logic                    pc_branch_wr, pc_branch_wr_d;
  logic                    decode_en, decode_en_d;
  logic                    alu_in_en, alu_in_en_d;
  logic                    alu_out_en, alu_out_en_d;
  logic                    status_wr, status_wr_d;
  logic [NUM_WB_PORTS-1:0] reg_wr_en, reg_wr_en_d;
  logic                    mem_req, mem_req_d;
  logic                    mem_wr, mem_wr_d;
  logic                    fault, fault_d;
`ifdef CTRL_IRQ_EN
  logic                    irq_ack, irq_ack_d;
  logic                    pc_vector_wr, pc_vector_wr_d;
`endif

  // Only the four flag bits of the PSW take part in branch conditions.
  logic unused_psw;
  assign unused_psw = ^bus.status_reg[15:4];

  // Branch condition from PSW flags: bit0 C, bit1 Z, bit2 N, bit3 V.
  always_comb begin
    cond_true = 1'b0;
    case (bus.branch_cond)
      3'd0:    cond_true = bus.status_reg[1];
      3'd1:    cond_true = !bus.status_reg[1];
      3'd2:    cond_true = bus.status_reg[0];
      3'd3:    cond_true = !bus.status_reg[0];
      3'd4:    cond_true = bus.status_reg[2];
      3'd5:    cond_true = (bus.status_reg[2] == bus.status_reg[3]);
      3'd6:    cond_true = (bus.status_reg[2] != bus.status_reg[3]);
      default: cond_true = 1'b1;
    endcase
  end

  // Saturating increment of the wait counter.
  always_comb begin
    cnt_inc = {1'b0, cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
    cnt_sat = cnt_inc[TIMEOUT_W] ? cnt : cnt_inc[TIMEOUT_W-1:0];
  end

  // Next state, wait counter and the strobes belonging to the next state.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    fetch_en_d     = 1'b0;
    pc_fetch_wr_d  = 1'b0;
    pc_branch_wr_d = 1'b0;
    decode_en_d    = 1'b0;
    alu_in_en_d    = 1'b0;
    alu_out_en_d   = 1'b0;
    status_wr_d    = 1'b0;
    reg_wr_en_d    = '0;
    mem_req_d      = 1'b0;
    mem_wr_d       = 1'b0;
    fault_d        = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack_d      = 1'b0;
    pc_vector_wr_d = 1'b0;
    after_instr    = bus.irq_req ? IRQ_ENTRY : FETCH;
`else
    after_instr    = FETCH;
`endif

    case (state)
      IDLE:          if (bus.run) state_d = FETCH;
      FETCH:         state_d = WAIT_FETCH;
      WAIT_FETCH: begin
        if (bus.fetch_done) begin
          state_d = DECODE;
        end else if ((FETCH_LIM != 0) && (32'(cnt_inc) >= FETCH_LIM)) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      DECODE:        state_d = OPERAND_FETCH;
      OPERAND_FETCH: state_d = ((bus.macro_op == OP_SVC) || (bus.macro_op == OP_CEX)) ?
                               NOP_EXEC : EXECUTE;
      EXECUTE:       state_d = ((bus.macro_op == OP_LD) || (bus.macro_op == OP_ST)) ?
                               MEM_WAIT : WRITE_BACK;
      MEM_WAIT: begin
        if (bus.mem_done) begin
          state_d = (bus.macro_op == OP_LD) ? WRITE_BACK : after_instr;
        end else if ((MEM_LIM != 0) && (32'(cnt_inc) >= MEM_LIM)) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      WRITE_BACK:    state_d = after_instr;
      NOP_EXEC:      state_d = after_instr;
      FAULT:         state_d = FAULT;
`ifdef CTRL_IRQ_EN
      IRQ_ENTRY:     state_d = FETCH;
`endif
      default:       state_d = IDLE;
    endcase

    // Every state change clears the counter, so each wait starts from zero.
    if (state_d != state) cnt_d = '0;

    case (state_d)
      FETCH:         fetch_en_d = 1'b1;
      DECODE: begin
        decode_en_d   = 1'b1;
        pc_fetch_wr_d = 1'b1;
      end
      OPERAND_FETCH: alu_in_en_d = 1'b1;
      EXECUTE: begin
        alu_out_en_d   = 1'b1;
        pc_branch_wr_d = bus.branch_en & cond_true;
      end
      MEM_WAIT: begin
        mem_req_d = 1'b1;
        mem_wr_d  = (bus.macro_op == OP_ST);
      end
      WRITE_BACK: begin
        reg_wr_en_d = bus.reg_wb_mode;
        status_wr_d = bus.new_status_en;
      end
      FAULT:         fault_d = 1'b1;
`ifdef CTRL_IRQ_EN
      IRQ_ENTRY: begin
        irq_ack_d      = 1'b1;
        pc_vector_wr_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fetch_en     <= 1'b0;
      pc_fetch_wr  <= 1'b0;
      pc_branch_wr <= 1'b0;
      decode_en    <= 1'b0;
      alu_in_en    <= 1'b0;
      alu_out_en   <= 1'b0;
      status_wr    <= 1'b0;
      reg_wr_en    <= '0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      fault        <= 1'b0;
`ifdef CTRL_IRQ_EN
      irq_ack      <= 1'b0;
      pc_vector_wr <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      fetch_en     <= fetch_en_d;
      pc_fetch_wr  <= pc_fetch_wr_d;
      pc_branch_wr <= pc_branch_wr_d;
      decode_en    <= decode_en_d;
      alu_in_en    <= alu_in_en_d;
      alu_out_en   <= alu_out_en_d;
      status_wr    <= status_wr_d;
      reg_wr_en    <= reg_wr_en_d;
      mem_req      <= mem_req_d;
      mem_wr       <= mem_wr_d;
      fault        <= fault_d;
`ifdef CTRL_IRQ_EN
      irq_ack      <= irq_ack_d;
      pc_vector_wr <= pc_vector_wr_d;
`endif
    end
  end

  assign bus.fetch_en     = fetch_en;
  assign bus.pc_fetch_wr  = pc_fetch_wr;
  assign bus.pc_branch_wr = pc_branch_wr;
  assign bus.decode_en    = decode_en;
  assign bus.alu_in_en    = alu_in_en;
  assign bus.alu_out_en   = alu_out_en;
  assign bus.status_wr    = status_wr;
  assign bus.reg_wr_en    = reg_wr_en;
  assign bus.mem_req      = mem_req;
  assign bus.mem_wr       = mem_wr;
  assign bus.fault        = fault;
  assign bus.state_o      = state;
`ifdef CTRL_IRQ_EN
  assign bus.irq_ack      = irq_ack;
  assign bus.pc_vector_wr = pc_vector_wr;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer.
// The driver pushes the hand-derived state and strobe record expected after
// each clock edge; a monitor on the falling edge pops and compares.
module tb_control_sequencer;

  localparam int W = 18;  // {state[3:0], strobes[13:0]}

  // Strobe bit positions inside a record
  localparam logic [13:0] M_VEC  = 14'h0001;
  localparam logic [13:0] M_ACK  = 14'h0002;
  localparam logic [13:0] M_FE   = 14'h0004;
  localparam logic [13:0] M_PCF  = 14'h0008;
  localparam logic [13:0] M_PCB  = 14'h0010;
  localparam logic [13:0] M_DEC  = 14'h0020;
  localparam logic [13:0] M_AIN  = 14'h0040;
  localparam logic [13:0] M_AOUT = 14'h0080;
  localparam logic [13:0] M_SW   = 14'h0100;
  localparam logic [13:0] M_MREQ = 14'h0800;
  localparam logic [13:0] M_MWR  = 14'h1000;
  localparam logic [13:0] M_FLT  = 14'h2000;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_WAIT = 4'd2, S_DEC = 4'd3,
                         S_OPF = 4'd4, S_EXE = 4'd5, S_MEM = 4'd6, S_WB = 4'd7,
                         S_NOP = 4'd8, S_FLT = 4'd9, S_IRQ = 4'd11;

  localparam logic [2:0] OP_BL = 3'd0, OP_CBR = 3'd1, OP_ALU = 3'd2, OP_LD = 3'd3,
                         OP_ST = 3'd4, OP_SVC = 3'd5, OP_CEX = 3'd6, OP_MOVI = 3'd7;

  localparam logic [2:0] C_EQ = 3'd0, C_GE = 3'd5, C_LT = 3'd6, C_AL = 3'd7;

  logic clk;
  logic reset;
  logic mon_en;
  int   total;
  int   bad;
  logic [W-1:0] exp_q[$];

  control_sequencer_if #(.NUM_WB_PORTS(2)) bus ();

  control_sequencer #(
    .TIMEOUT_W(4), .FETCH_TIMEOUT(15), .MEM_TIMEOUT(15), .NUM_WB_PORTS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Clock and initial values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed record, with interrupt bits zero when the feature is absent.
  logic [13:0] obs_str;
  always_comb begin
    obs_str = {bus.fault, bus.mem_wr, bus.mem_req, bus.reg_wr_en, bus.status_wr,
               bus.alu_out_en, bus.alu_in_en, bus.decode_en, bus.pc_branch_wr,
               bus.pc_fetch_wr, bus.fetch_en, 2'b00};
`ifdef CTRL_IRQ_EN
    obs_str[1] = bus.irq_ack;
    obs_str[0] = bus.pc_vector_wr;
`endif
  end

  // Monitor: one comparison per cycle while enabled
  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      got = {bus.state_o, obs_str};
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_output at %0t: got %h, no expectation queued", $time, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad = bad + 1;
          $display("FAIL cycle_check #%0d at %0t: got state=%0d strobes=%h, want state=%0d strobes=%h",
                   total, $time, got[17:14], got[13:0], want[17:14], want[13:0]);
        end
      end
    end
  end

  // Wait one edge; afterwards the DUT must show this record.
  task automatic expect_next(input logic [3:0] st, input logic [13:0] str);
    @(posedge clk);
    #1;
    exp_q.push_back({st, str});
  endtask

  // Final edge of an instruction: optional interrupt entry, then FETCH.
  task automatic to_fetch(input logic irq);
`ifdef CTRL_IRQ_EN
    bus.irq_req = irq;
    if (irq) begin
      expect_next(S_IRQ, M_ACK | M_VEC);
      bus.irq_req = 1'b0;
    end
`else
    if (irq) $display("note: interrupt request skipped, feature not built");
`endif
    expect_next(S_FETCH, M_FE);
  endtask

  // Runs one instruction starting with FETCH visible and ending in FETCH.
  // fw/mw: cycles the done signal is held low before it is given.
  task automatic instr(input logic [2:0] op, input logic [1:0] wb, input logic nse,
                       input logic br_en, input logic [2:0] cond, input logic [15:0] psw,
                       input logic exp_br, input int fw, input int mw, input logic irq);
    bus.macro_op      = op;
    bus.reg_wb_mode   = wb;
    bus.new_status_en = nse;
    bus.branch_en     = br_en;
    bus.branch_cond   = cond;
    bus.status_reg    = psw;
    bus.fetch_done    = 1'b0;
    bus.mem_done      = 1'b0;
    expect_next(S_WAIT, 14'h0);
    for (int i = 0; i < fw; i++) expect_next(S_WAIT, 14'h0);
    bus.fetch_done = 1'b1;
    expect_next(S_DEC, M_DEC | M_PCF);
    bus.fetch_done = 1'b0;
    expect_next(S_OPF, M_AIN);
    if (op == OP_SVC || op == OP_CEX) begin
      expect_next(S_NOP, 14'h0);
      to_fetch(irq);
    end else begin
      expect_next(S_EXE, M_AOUT | (exp_br ? M_PCB : 14'h0));
      if (op == OP_LD || op == OP_ST) begin
        expect_next(S_MEM, M_MREQ | ((op == OP_ST) ? M_MWR : 14'h0));
        for (int i = 0; i < mw; i++)
          expect_next(S_MEM, M_MREQ | ((op == OP_ST) ? M_MWR : 14'h0));
        bus.mem_done = 1'b1;
        if (op == OP_LD) begin
          expect_next(S_WB, {3'b000, wb, nse, 8'h00});
          bus.mem_done = 1'b0;
          to_fetch(irq);
        end else begin
          to_fetch(irq);
          bus.mem_done = 1'b0;
        end
      end else begin
        expect_next(S_WB, {3'b000, wb, nse, 8'h00});
        to_fetch(irq);
      end
    end
  endtask

  // Stimulus
  initial begin
    total  = 0;
    bad    = 0;
    mon_en = 1'b1;
    reset  = 1'b1;
    bus.run = 1'b0;
    bus.fetch_done = 1'b0;
    bus.mem_done = 1'b0;
    bus.branch_en = 1'b0;
    bus.new_status_en = 1'b0;
    bus.reg_wb_mode = 2'b00;
    bus.branch_cond = 3'd0;
    bus.macro_op = 3'd0;
    bus.status_reg = 16'h0000;
`ifdef CTRL_IRQ_EN
    bus.irq_req = 1'b0;
`endif

    // Reset state
    expect_next(S_IDLE, 14'h0);
    expect_next(S_IDLE, 14'h0);
    reset = 1'b0;
    expect_next(S_IDLE, 14'h0);
    bus.run = 1'b1;
    expect_next(S_FETCH, M_FE);
    bus.run = 1'b0;  // dropping run mid-program has no effect

    // ALU op, status update, lane 0 write
    instr(OP_ALU, 2'b01, 1'b1, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    // Conditional branches: GE with N=V=1 taken, GE with N=1 V=0 not taken
    instr(OP_CBR, 2'b00, 1'b0, 1'b1, C_GE, 16'h000C, 1'b1, 0, 0, 1'b0);
    instr(OP_CBR, 2'b00, 1'b0, 1'b1, C_GE, 16'h0004, 1'b0, 0, 0, 1'b0);
    instr(OP_CBR, 2'b00, 1'b0, 1'b1, C_LT, 16'h0004, 1'b1, 0, 0, 1'b0);
    instr(OP_CBR, 2'b00, 1'b0, 1'b1, C_EQ, 16'hFFFD, 1'b0, 0, 0, 1'b0);
    instr(OP_CBR, 2'b00, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    instr(OP_BL,  2'b10, 1'b0, 1'b1, C_AL, 16'h0000, 1'b1, 1, 0, 1'b0);
    // Load: fetch after 2 idle wait cycles, mem_req high 3 cycles
    instr(OP_LD,  2'b10, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 2, 2, 1'b0);
    // Store: back to FETCH without write-back
    instr(OP_ST,  2'b11, 1'b1, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    // SVC/CEX take the NOP path; MOVI writes back
    instr(OP_SVC, 2'b11, 1'b1, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    instr(OP_CEX, 2'b11, 1'b1, 1'b1, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    instr(OP_MOVI, 2'b01, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b0);
    // mem_done in the same cycle as the timeout wins (15th wait cycle)
    instr(OP_LD,  2'b01, 1'b1, 1'b0, C_AL, 16'h0000, 1'b0, 0, 14, 1'b0);
    instr(OP_ST,  2'b00, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 14, 14, 1'b0);
    // fetch_done in the last permitted wait cycle
    instr(OP_ALU, 2'b10, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 14, 0, 1'b0);
`ifdef CTRL_IRQ_EN
    // Interrupt entry after write-back, NOP and store
    instr(OP_ALU, 2'b01, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b1);
    instr(OP_SVC, 2'b00, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 0, 0, 1'b1);
    instr(OP_ST,  2'b00, 1'b0, 1'b0, C_AL, 16'h0000, 1'b0, 0, 1, 1'b1);
`endif

    // Reset asserted while in MEM_WAIT
    bus.macro_op = OP_LD;
    bus.fetch_done = 1'b1;
    expect_next(S_WAIT, 14'h0);
    expect_next(S_DEC, M_DEC | M_PCF);
    bus.fetch_done = 1'b0;
    expect_next(S_OPF, M_AIN);
    expect_next(S_EXE, M_AOUT);
    expect_next(S_MEM, M_MREQ);
    reset = 1'b1;
    expect_next(S_IDLE, 14'h0);
    reset = 1'b0;
    expect_next(S_IDLE, 14'h0);
    bus.run = 1'b1;
    expect_next(S_FETCH, M_FE);
    bus.run = 1'b0;

    // Fetch timeout: 15 wait cycles, then sticky FAULT
    bus.macro_op = OP_ALU;
    for (int i = 0; i < 15; i++) expect_next(S_WAIT, 14'h0);
    expect_next(S_FLT, M_FLT);
    bus.run = 1'b1;
    bus.fetch_done = 1'b1;
    bus.mem_done = 1'b1;
    expect_next(S_FLT, M_FLT);
    expect_next(S_FLT, M_FLT);
    bus.run = 1'b0;
    bus.fetch_done = 1'b0;
    bus.mem_done = 1'b0;
    reset = 1'b1;
    expect_next(S_IDLE, 14'h0);
    reset = 1'b0;
    expect_next(S_IDLE, 14'h0);
    expect_next(S_IDLE, 14'h0);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
